// File: rtl/wb_cache.sv
// -----------------------------------------------------------------------------
// wb_cache
//   Direct-mapped, write-back, write-allocate data cache. One word per line.
//   The CPU side is a valid/ready request port. The memory side is a
//   valid/ready port that carries evictions (writes) and refills (reads).
//
// Parameters
//   BITS          data word width (multiple of 8)
//   ADDRESS_BITS  CPU byte-address width
//   INDEX_BITS    log2 of the line count
//   CNT_BITS      width of each statistics counter
//
// Ports
//   CLK, RSTb                clock, asynchronous active-low reset
//   cpu_addr/_data_in/_wstrb/_wr/_valid   CPU request, held until cpu_ready
//   cpu_ready, cpu_data_out  one-cycle completion pulse and read data
//   mem_addr/_wdata/_wr/_valid            memory request, held until accepted
//   mem_ready, mem_rdata     memory accept and refill data
//   hit_cnt, miss_cnt        saturating lookup statistics
// -----------------------------------------------------------------------------
module wb_cache #(
  parameter int BITS         = 32,
  parameter int ADDRESS_BITS = 28,
  parameter int INDEX_BITS   = 10,
  parameter int CNT_BITS     = 16
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic [ADDRESS_BITS-1:0] cpu_addr,
  input  logic [BITS-1:0]         cpu_data_in,
  input  logic [BITS/8-1:0]       cpu_wstrb,
  input  logic                    cpu_wr,
  input  logic                    cpu_valid,
  output logic                    cpu_ready,
  output logic [BITS-1:0]         cpu_data_out,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [BITS-1:0]         mem_wdata,
  output logic                    mem_wr,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  input  logic [BITS-1:0]         mem_rdata,
  output logic [CNT_BITS-1:0]     hit_cnt,
  output logic [CNT_BITS-1:0]     miss_cnt
);

  localparam int TAG_BITS  = ADDRESS_BITS - INDEX_BITS - 2;
  localparam int DEPTH     = 1 << INDEX_BITS;
  localparam int STRB_BITS = BITS / 8;
  localparam int WADDR_BITS = ADDRESS_BITS - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVICT,
    S_FILL,
    S_RESPOND
  } state_e;

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [BITS-1:0]     data;
  } line_t;

  function automatic logic [BITS-1:0] merge_bytes(input logic [BITS-1:0]      old_w,
                                                  input logic [BITS-1:0]      new_w,
                                                  input logic [STRB_BITS-1:0] strb);
    logic [BITS-1:0] res;
    res = old_w;
    for (int b = 0; b < STRB_BITS; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Byte-offset bits are never used; the name keeps lint quiet about them.
  logic unused_byte_offset;
  assign unused_byte_offset = ^cpu_addr[1:0];

  state_e                  state_q, state_d;
  logic                    rsp_q, rsp_d;          // RESPOND: 0 = re-read array, 1 = reply
  logic [WADDR_BITS-1:0]   req_word_q, req_word_d;
  logic [BITS-1:0]         req_wdata_q, req_wdata_d;
  logic [STRB_BITS-1:0]    req_wstrb_q, req_wstrb_d;
  logic                    req_wr_q, req_wr_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH-1:0]        dirty_q, dirty_d;
  logic [CNT_BITS-1:0]     hit_cnt_q, hit_cnt_d;
  logic [CNT_BITS-1:0]     miss_cnt_q, miss_cnt_d;
  logic                    mem_valid_q, mem_valid_d;
  logic                    mem_wr_q, mem_wr_d;
  logic [ADDRESS_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [BITS-1:0]         mem_wdata_q, mem_wdata_d;

  // Array port controls
  logic                    ram_re, ram_we;
  logic [INDEX_BITS-1:0]   ram_raddr, ram_waddr;
  line_t                   ram_wline;
  line_t                   ram_rd_q;
  line_t                   mem_q [DEPTH];

  logic [INDEX_BITS-1:0]   req_idx;
  logic [TAG_BITS-1:0]     req_tag;
  logic                    hit;
  logic                    mem_accept;

  assign req_idx    = req_word_q[INDEX_BITS-1:0];
  assign req_tag    = req_word_q[WADDR_BITS-1:INDEX_BITS];
  assign hit        = valid_q[req_idx] && (ram_rd_q.tag == req_tag);
  assign mem_accept = mem_valid_q && mem_ready;

  // NOTE: the tag/data array has no reset; it maps onto block RAM, and line
  // validity is tracked in the valid_q flops, which are reset instead.
  always_ff @(posedge CLK) begin
    if (ram_we) mem_q[ram_waddr] <= ram_wline;
    if (ram_re) ram_rd_q <= mem_q[ram_raddr];
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q     <= S_IDLE;
      rsp_q       <= 1'b0;
      req_word_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      req_wr_q    <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_q       <= rsp_d;
      req_word_q  <= req_word_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      req_wr_q    <= req_wr_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    rsp_d        = rsp_q;
    req_word_d   = req_word_q;
    req_wdata_d  = req_wdata_q;
    req_wstrb_d  = req_wstrb_q;
    req_wr_d     = req_wr_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    mem_valid_d  = mem_valid_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ram_re       = 1'b0;
    ram_raddr    = req_idx;
    ram_we       = 1'b0;
    ram_waddr    = req_idx;
    ram_wline    = '{tag: req_tag, data: ram_rd_q.data};
    cpu_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_valid) begin
          req_word_d  = cpu_addr[ADDRESS_BITS-1:2];
          req_wdata_d = cpu_data_in;
          req_wstrb_d = cpu_wstrb;
          req_wr_d    = cpu_wr;
          ram_re      = 1'b1;
          ram_raddr   = cpu_addr[INDEX_BITS+1:2];
          state_d     = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (hit) begin
          cpu_ready = 1'b1;
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_BITS'(1);
          if (req_wr_q) begin
            ram_we            = 1'b1;
            ram_wline.data    = merge_bytes(ram_rd_q.data, req_wdata_q, req_wstrb_q);
            dirty_d[req_idx]  = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_BITS'(1);
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? S_EVICT : S_FILL;
        end
      end

      // Memory requests are launched from a register one cycle after the
      // state is entered; ram_rd_q still holds the victim line from LOOKUP.
      S_EVICT: begin
        if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = {ram_rd_q.tag, req_idx, 2'b00};
          mem_wdata_d = ram_rd_q.data;
        end else if (mem_accept) begin
          mem_valid_d = 1'b0;
          state_d     = S_FILL;
        end
      end

      S_FILL: begin
        if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = {req_tag, req_idx, 2'b00};
        end else if (mem_accept) begin
          mem_valid_d      = 1'b0;
          ram_we           = 1'b1;
          ram_wline.data   = req_wr_q ? merge_bytes(mem_rdata, req_wdata_q, req_wstrb_q)
                                      : mem_rdata;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = req_wr_q;
          state_d          = S_RESPOND;
        end
      end

      // The reply word is read back through the single array read port so
      // cpu_data_out always comes from ram_rd_q.
      S_RESPOND: begin
        if (!rsp_q) begin
          ram_re = 1'b1;
          rsp_d  = 1'b1;
        end else begin
          cpu_ready = 1'b1;
          rsp_d     = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cpu_data_out = cpu_ready ? ram_rd_q.data : '0;
  assign mem_valid    = mem_valid_q;
  assign mem_wr       = mem_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign hit_cnt      = hit_cnt_q;
  assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_wb_cache.sv
// -----------------------------------------------------------------------------
// tb_wb_cache
//   Self-checking bench for wb_cache. Expected CPU replies and memory
//   transfers are queued when a request is issued and popped when the DUT
//   produces them. A small backing-store model answers refills.
// -----------------------------------------------------------------------------
module tb_wb_cache;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data_in;
  logic [3:0]    cpu_wstrb;
  logic          cpu_wr;
  logic          cpu_valid;
  logic          cpu_ready;
  logic [DW-1:0] cpu_data_out;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr;
  logic          mem_valid;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  wb_cache #(
    .BITS(DW), .ADDRESS_BITS(AW), .INDEX_BITS(10), .CNT_BITS(CW)
  ) dut (
    .CLK          (clk),
    .RSTb         (rst_n),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_wstrb    (cpu_wstrb),
    .cpu_wr       (cpu_wr),
    .cpu_valid    (cpu_valid),
    .cpu_ready    (cpu_ready),
    .cpu_data_out (cpu_data_out),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wr       (mem_wr),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [DW-1:0] data;
  } cpu_exp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  cpu_exp_t      cpu_exp_q[$];
  mem_exp_t      mem_exp_q[$];
  logic [DW-1:0] bmem [logic [AW-1:0]];

  int            n_checks = 0;
  int            n_errors = 0;
  logic [CW-1:0] exp_hits = '0;
  logic [CW-1:0] exp_misses = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] bmem_read(input logic [AW-1:0] a);
    if (bmem.exists(a)) return bmem[a];
    return 32'hDEAD_0000 ^ DW'(a);
  endfunction

  task automatic expect_resp(input logic wr, input logic [DW-1:0] data);
    cpu_exp_t e;
    e.wr = wr;
    e.data = data;
    cpu_exp_q.push_back(e);
  endtask

  task automatic expect_mem(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    mem_exp_t e;
    e.wr = wr;
    e.addr = addr;
    e.wdata = wdata;
    mem_exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one CPU request, serve the memory port, and score everything that
  // comes out until cpu_ready. fill_stall holds mem_ready low on refills.
  task automatic cpu_req(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                         input logic [3:0] strb, input int fill_stall, input logic exp_hit);
    int            k, acc_at, resp_at, wr_acc_at, mem_cycles, stall_left;
    logic          done, seen;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_wdata;
    logic          hold_wr;
    cpu_exp_t      ce;
    mem_exp_t      me;
    cpu_addr = addr; cpu_wr = wr; cpu_data_in = wdata; cpu_wstrb = strb; cpu_valid = 1'b1;
    k = 0; acc_at = -1; resp_at = -1; wr_acc_at = -1; mem_cycles = 0;
    stall_left = fill_stall; done = 1'b0; seen = 1'b0;
    hold_addr = '0; hold_wdata = '0; hold_wr = 1'b0;
    while (!done && k < 100) begin
      mem_ready = 1'b0;
      if (mem_valid) begin
        mem_cycles++;
        if (!seen) begin
          hold_addr = mem_addr; hold_wdata = mem_wdata; hold_wr = mem_wr;
          if (!mem_wr && wr_acc_at >= 0) check("evict_fill_gap", 64'(k - wr_acc_at), 64'd2);
        end else begin
          check("mem_hold", 64'({mem_wr, mem_addr, mem_wdata}), 64'({hold_wr, hold_addr, hold_wdata}));
        end
        if (!mem_wr && stall_left > 0) begin
          stall_left--;
        end else begin
          mem_ready = 1'b1;
          mem_rdata = mem_wr ? '0 : bmem_read(mem_addr);
          check("mem_expected", 64'(mem_exp_q.size() != 0), 64'd1);
          if (mem_exp_q.size() != 0) begin
            me = mem_exp_q.pop_front();
            check("mem_wr", 64'(mem_wr), 64'(me.wr));
            check("mem_addr", 64'(mem_addr), 64'(me.addr));
            if (me.wr) check("mem_wdata", 64'(mem_wdata), 64'(me.wdata));
          end
          if (mem_wr) begin
            bmem[mem_addr] = mem_wdata;
            wr_acc_at = k;
          end
          acc_at = k;
        end
      end
      seen = mem_valid && !mem_ready;
      if (cpu_ready) begin
        resp_at = k;
        done = 1'b1;
        check("resp_expected", 64'(cpu_exp_q.size() != 0), 64'd1);
        if (cpu_exp_q.size() != 0) begin
          ce = cpu_exp_q.pop_front();
          if (!ce.wr) check("rdata", 64'(cpu_data_out), 64'(ce.data));
        end
      end
      tick();
      k++;
      if (done) begin
        cpu_valid = 1'b0;
        mem_ready = 1'b0;
      end
    end
    cpu_valid = 1'b0;
    mem_ready = 1'b0;
    check("ready_seen", 64'(done), 64'd1);
    check("ready_pulse", 64'(cpu_ready), 64'd0);
    if (exp_hit) begin
      check("hit_latency", 64'(resp_at), 64'd1);
      check("hit_no_mem", 64'(mem_cycles), 64'd0);
      if (exp_hits != '1) exp_hits++;
    end else begin
      check("fill_to_ready", 64'(resp_at - acc_at), 64'd2);
      if (exp_misses != '1) exp_misses++;
    end
    check("hit_cnt", 64'(hit_cnt), 64'(exp_hits));
    check("miss_cnt", 64'(miss_cnt), 64'(exp_misses));
    check("mem_drained", 64'(mem_exp_q.size()), 64'd0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    cpu_addr = '0; cpu_data_in = '0; cpu_wstrb = '0; cpu_wr = 1'b0; cpu_valid = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    bmem[28'h0040] = 32'hA5A5_0001;
    bmem[28'h1040] = 32'h5A5A_1040;
    tick(); tick();

    // Reset state
    check("rst_cpu_ready", 64'(cpu_ready), 64'd0);
    check("rst_cpu_data", 64'(cpu_data_out), 64'd0);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_wr", 64'(mem_wr), 64'd0);
    check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    rst_n = 1'b1;

    // No activity while cpu_valid is low
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_quiet", 64'({mem_valid, cpu_ready}), 64'd0);
    end

    // Cold read miss, then hit, then partial-write hit and read-back
    expect_mem(1'b0, 28'h0040, '0);
    expect_resp(1'b0, 32'hA5A5_0001);
    cpu_req(28'h0040, 1'b0, '0, 4'h0, 0, 1'b0);
    expect_resp(1'b0, 32'hA5A5_0001);
    cpu_req(28'h0040, 1'b0, '0, 4'h0, 0, 1'b1);
    expect_resp(1'b1, '0);
    cpu_req(28'h0040, 1'b1, 32'h1122_3344, 4'b0011, 0, 1'b1);
    expect_resp(1'b0, 32'hA5A5_3344);
    cpu_req(28'h0040, 1'b0, '0, 4'h0, 0, 1'b1);

    // Conflict miss on a dirty line with a stalled refill
    expect_mem(1'b1, 28'h0040, 32'hA5A5_3344);
    expect_mem(1'b0, 28'h1040, '0);
    expect_resp(1'b0, 32'h5A5A_1040);
    cpu_req(28'h1040, 1'b0, '0, 4'h0, 7, 1'b0);

    // Zero-strobe write still marks the line dirty
    expect_resp(1'b1, '0);
    cpu_req(28'h1040, 1'b1, 32'hCAFE_BABE, 4'b0000, 0, 1'b1);
    expect_mem(1'b1, 28'h1040, 32'h5A5A_1040);
    expect_mem(1'b0, 28'h0040, '0);
    expect_resp(1'b0, 32'hA5A5_3344);
    cpu_req(28'h0040, 1'b0, '0, 4'h0, 2, 1'b0);

    // Write misses: clean allocate, then dirty allocate with partial merge
    expect_mem(1'b0, 28'h2080, '0);
    expect_resp(1'b1, '0);
    cpu_req(28'h2080, 1'b1, 32'h1234_5678, 4'b1111, 0, 1'b0);
    expect_resp(1'b0, 32'h1234_5678);
    cpu_req(28'h2080, 1'b0, '0, 4'h0, 0, 1'b1);
    expect_mem(1'b1, 28'h2080, 32'h1234_5678);
    expect_mem(1'b0, 28'h3080, '0);
    expect_resp(1'b1, '0);
    cpu_req(28'h3080, 1'b1, 32'h0000_00EE, 4'b0001, 1, 1'b0);
    expect_resp(1'b0, 32'hDEAD_30EE);
    cpu_req(28'h3080, 1'b0, '0, 4'h0, 0, 1'b1);

    // Hit counter saturates and does not wrap
    for (int i = 0; i < 12; i++) begin
      expect_resp(1'b0, 32'hDEAD_30EE);
      cpu_req(28'h3080, 1'b0, '0, 4'h0, 0, 1'b1);
    end
    check("hit_saturated", 64'(hit_cnt), 64'hF);
    expect_resp(1'b1, '0);
    cpu_req(28'h0040, 1'b1, 32'h7777_7777, 4'b1111, 0, 1'b1);

    // Reset in the middle of an eviction
    cpu_addr = 28'h1040; cpu_wr = 1'b0; cpu_wstrb = '0; cpu_valid = 1'b1;
    k = 0;
    while (!(mem_valid && mem_wr) && k < 20) begin
      tick();
      k++;
    end
    check("evict_seen", 64'(mem_valid && mem_wr), 64'd1);
    check("evict_addr", 64'(mem_addr), 64'h0040);
    check("evict_data", 64'(mem_wdata), 64'h7777_7777);
    rst_n = 1'b0;
    #1;
    check("abort_mem_valid", 64'(mem_valid), 64'd0);
    check("abort_cpu_ready", 64'(cpu_ready), 64'd0);
    check("abort_mem_addr", 64'(mem_addr), 64'd0);
    check("abort_mem_wr", 64'(mem_wr), 64'd0);
    check("abort_counters", 64'({hit_cnt, miss_cnt}), 64'd0);
    cpu_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_hits = '0;
    exp_misses = '0;
    tick();

    // After reset the old dirty line is gone: clean miss, no eviction
    expect_mem(1'b0, 28'h0040, '0);
    expect_resp(1'b0, 32'hA5A5_3344);
    cpu_req(28'h0040, 1'b0, '0, 4'h0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
